core_drive_ctrl: RTL and testbench

Digital-side driver and event capture for one analog cochlea channel core; the I and Q cores each get one instance. It generates the `cclk`, `div2` and `lo` drive clocks and closes the comparator loop by returning `fb1`. It captures comparator decisions from `high_buf`, sampled on rising edges of `phi1b_dig`, and queues fired events with a timestamp for readout through a valid/ready port.

---
 rtl/core_ctrl_pkg.sv | 23 ++
 rtl/core_drive_ctrl_if.sv | 15 +
 rtl/core_ctrl_fifo.sv | 53 +++++
 rtl/core_drive_ctrl.sv | 178 +++++++++++++++++
 tb/tb_core_drive_ctrl.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_ctrl_pkg.sv
// Shared constants and event-word layout for the cochlea channel core driver.
// Optional build macro affecting users of this package: CORE_CTRL_OVF_CNT_EN.
package core_ctrl_pkg;

  localparam int DEF_DIV_W      = 8;
  localparam int DEF_TS_W       = 16;
  localparam int DEF_FIFO_DEPTH = 8;
  localparam int EVT_W          = DEF_TS_W + 2;

  // Event word is {lo, div2, ts}: lo at the MSB, div2 below it, ts in the low bits.
  function automatic int evt_w(input int ts_w);
    return ts_w + 2;
  endfunction

  function automatic int evt_lo_pos(input int ts_w);
    return ts_w + 1;
  endfunction

  function automatic int evt_div2_pos(input int ts_w);
    return ts_w;
  endfunction

endpackage

// File: rtl/core_drive_ctrl_if.sv
// Event readout valid/ready channel; the driver is the master, the reader the slave.
interface core_drive_ctrl_if
  import core_ctrl_pkg::*;
#(
  parameter int TS_W = DEF_TS_W
) ();

  logic                      evt_valid;
  logic                      evt_ready;
  logic [evt_w(TS_W)-1:0]    evt_data;

  modport master (output evt_valid, output evt_data, input  evt_ready);
  modport slave  (input  evt_valid, input  evt_data, output evt_ready);

endinterface

// File: rtl/core_ctrl_fifo.sv
// Synchronous event FIFO with simultaneous push/pop and a drop-on-full pulse.
// DEPTH must be a power of two, at least 2.
module core_ctrl_fifo #(
  parameter int W     = 18,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         drop
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         full, pop_ok, push_ok;

  // One extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && full && !pop_ok;
  assign rdata   = empty ? '0 : mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_ok) wr_d = wr_q + 1'b1;
    if (pop_ok)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // NOTE: storage has no reset; the pointers alone define validity and rdata is masked when empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/core_drive_ctrl.sv
// Drive-clock generator and comparator event capture for one cochlea channel core.
// Define CORE_CTRL_OVF_CNT_EN to add the saturating ovf_cnt drop counter port.
module core_drive_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int DIV_W      = DEF_DIV_W,
  parameter int TS_W       = DEF_TS_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             en,
  input  logic [DIV_W-1:0] cclk_half,
  input  logic [DIV_W-1:0] lo_half,
  output logic             cclk,
  output logic             div2,
  output logic             lo,
  output logic             fb1,
  input  logic             high_buf,
  input  logic             phi1b_dig,
  core_drive_ctrl_if.master evt,
  output logic             ovf,
  input  logic             clr_ovf
`ifdef CORE_CTRL_OVF_CNT_EN
  ,
  output logic [7:0]       ovf_cnt
`endif
);

  localparam int EW       = evt_w(TS_W);
  localparam int LO_POS   = evt_lo_pos(TS_W);
  localparam int DIV2_POS = evt_div2_pos(TS_W);

  logic [DIV_W-1:0] cnt_q, cnt_d, lo_cnt_q, lo_cnt_d;
  logic             cclk_q, cclk_d, div2_q, div2_d, lo_q, lo_d;
  logic             phi_meta_q, phi_meta_d, phi_sync_q, phi_sync_d, phi_prev_q, phi_prev_d;
  logic             high_meta_q, high_meta_d, high_sync_q, high_sync_d;
  logic             strobe_q, strobe_d, dec_q, dec_d, fb1_q, fb1_d, ovf_q, ovf_d;
  logic [TS_W-1:0]  ts_q, ts_d;
  logic [EW-1:0]    push_data, fifo_rdata;
  logic             push, pop, fifo_empty, drop;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cnt_d    = cnt_q;
    lo_cnt_d = lo_cnt_q;
    cclk_d   = cclk_q;
    div2_d   = div2_q;
    lo_d     = lo_q;
    if (!en) begin
      cnt_d    = '0;
      lo_cnt_d = '0;
      cclk_d   = 1'b0;
      div2_d   = 1'b0;
      lo_d     = 1'b0;
    end else if (cnt_q >= cclk_half) begin
      // >= keeps a shrinking cclk_half from letting the counter run past the new terminal.
      cnt_d  = '0;
      cclk_d = !cclk_q;
      if (!cclk_q) begin
        div2_d = !div2_q;
        if (lo_cnt_q >= lo_half) begin
          lo_cnt_d = '0;
          lo_d     = !lo_q;
        end else begin
          lo_cnt_d = lo_cnt_q + 1'b1;
        end
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    phi_meta_d  = phi1b_dig;
    phi_sync_d  = phi_meta_q;
    phi_prev_d  = phi_sync_q;
    high_meta_d = high_buf;
    high_sync_d = high_meta_q;
    strobe_d    = en && phi_sync_q && !phi_prev_q;
    dec_d       = high_sync_q;

    fb1_d = fb1_q;
    ts_d  = ts_q;
    if (strobe_q) begin
      fb1_d = dec_q;
      ts_d  = ts_q + 1'b1;
    end
    push                = strobe_q && dec_q;
    push_data           = '0;
    push_data[LO_POS]   = lo_q;
    push_data[DIV2_POS] = div2_q;
    push_data[TS_W-1:0] = ts_q;

    // A drop in the same cycle as clr_ovf must leave the flag set.
    ovf_d = ovf_q;
    if (drop)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cnt_q       <= '0;
      lo_cnt_q    <= '0;
      cclk_q      <= 1'b0;
      div2_q      <= 1'b0;
      lo_q        <= 1'b0;
      phi_meta_q  <= 1'b0;
      phi_sync_q  <= 1'b0;
      phi_prev_q  <= 1'b0;
      high_meta_q <= 1'b0;
      high_sync_q <= 1'b0;
      strobe_q    <= 1'b0;
      dec_q       <= 1'b0;
      fb1_q       <= 1'b0;
      ts_q        <= '0;
      ovf_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      lo_cnt_q    <= lo_cnt_d;
      cclk_q      <= cclk_d;
      div2_q      <= div2_d;
      lo_q        <= lo_d;
      phi_meta_q  <= phi_meta_d;
      phi_sync_q  <= phi_sync_d;
      phi_prev_q  <= phi_prev_d;
      high_meta_q <= high_meta_d;
      high_sync_q <= high_sync_d;
      strobe_q    <= strobe_d;
      dec_q       <= dec_d;
      fb1_q       <= fb1_d;
      ts_q        <= ts_d;
      ovf_q       <= ovf_d;
    end
  end

  assign pop = !fifo_empty && evt.evt_ready;

  core_ctrl_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .push  (push),
    .wdata (push_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .drop  (drop)
  );

`ifdef CORE_CTRL_OVF_CNT_EN
  logic [7:0] ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (drop) begin
      if (clr_ovf)                 ovf_cnt_d = 8'd1;
      else if (ovf_cnt_q != 8'hFF) ovf_cnt_d = ovf_cnt_q + 8'd1;
    end else if (clr_ovf) begin
      ovf_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) ovf_cnt_q <= 8'd0;
    else          ovf_cnt_q <= ovf_cnt_d;
  end

  assign ovf_cnt = ovf_cnt_q;
`endif

  assign cclk          = cclk_q;
  assign div2          = div2_q;
  assign lo            = lo_q;
  assign fb1           = fb1_q;
  assign ovf           = ovf_q;
  assign evt.evt_valid = !fifo_empty;
  assign evt.evt_data  = fifo_rdata;

endmodule

// File: tb/tb_core_drive_ctrl.sv
// Directed bench for core_drive_ctrl (TS_W=4 so the timestamp wrap is reachable),
// with a per-cycle comparison against an arithmetic/queue model of the channel.
module tb_core_drive_ctrl;

  localparam int TSW = 4;

  logic       clk = 1'b0;
  logic       rst, en, phi, hb, evt_ready, clr_ovf;
  logic [7:0] cclk_half, lo_half;
  logic       cclk, div2, lo, fb1, ovf, evt_valid;
  logic [5:0] evt_data;
`ifdef CORE_CTRL_OVF_CNT_EN
  logic [7:0] ovf_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = !clk;

  core_drive_ctrl_if #(.TS_W(TSW)) evt_if ();
  assign evt_if.evt_ready = evt_ready;
  assign evt_valid        = evt_if.evt_valid;
  assign evt_data         = evt_if.evt_data;

  core_drive_ctrl #(.DIV_W(8), .TS_W(TSW), .FIFO_DEPTH(8)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .en        (en),
    .cclk_half (cclk_half),
    .lo_half   (lo_half),
    .cclk      (cclk),
    .div2      (div2),
    .lo        (lo),
    .fb1       (fb1),
    .high_buf  (hb),
    .phi1b_dig (phi),
    .evt       (evt_if.master),
    .ovf       (ovf),
    .clr_ovf   (clr_ovf)
`ifdef CORE_CTRL_OVF_CNT_EN
    ,
    .ovf_cnt   (ovf_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: clocks from elapsed enabled cycles, events as a queue, strobe acts 3 edges after phi is seen high.
  typedef struct { int due; logic dec; } act_t;
  logic [5:0] mq[$];
  act_t       aq[$];
  int         e, t, m_cnt;
  logic       m_cclk, m_div2, m_lo, m_fb1, m_ovf, m_phi_prev;
  logic [3:0] m_ts;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete(); aq.delete();
      e = 0; t = 0; m_cnt = 0; m_ts = '0;
      m_cclk = 0; m_div2 = 0; m_lo = 0; m_fb1 = 0; m_ovf = 0; m_phi_prev = 0;
    end else begin
      logic       do_pop, drop, have;
      logic [5:0] ent;
      int         ph, r;
      do_pop = (mq.size() != 0) && evt_ready;
      drop = 0; have = 0; ent = '0;
      if (aq.size() != 0 && aq[0].due == e) begin
        m_fb1 = aq[0].dec;
        if (aq[0].dec) begin
          if (mq.size() == 8 && !do_pop) drop = 1;
          else begin have = 1; ent = {m_lo, m_div2, m_ts}; end
        end
        m_ts = m_ts + 4'd1;
        aq.delete(0);
      end
      if (do_pop) mq.delete(0);
      if (have) mq.push_back(ent);
      if (drop) begin
        m_ovf = 1;
        m_cnt = clr_ovf ? 1 : (m_cnt < 255 ? m_cnt + 1 : 255);
      end else if (clr_ovf) begin
        m_ovf = 0;
        m_cnt = 0;
      end
      t = en ? t + 1 : 0;
      if (en) begin
        ph     = t / (int'(cclk_half) + 1);
        r      = (ph + 1) / 2;
        m_cclk = (ph % 2) == 1;
        m_div2 = (r % 2) == 1;
        m_lo   = ((r / (int'(lo_half) + 1)) % 2) == 1;
      end else begin
        m_cclk = 0; m_div2 = 0; m_lo = 0;
      end
      if (phi && !m_phi_prev && en) aq.push_back('{e + 3, hb});
      m_phi_prev = phi;
      e++;
    end
  end

  always @(negedge clk) begin
    logic [5:0] exp_d;
    exp_d = (mq.size() != 0) ? mq[0] : 6'd0;
    check("m_cclk", cclk, m_cclk);
    check("m_div2", div2, m_div2);
    check("m_lo", lo, m_lo);
    check("m_fb1", fb1, m_fb1);
    check("m_ovf", ovf, m_ovf);
    check("m_evt_valid", evt_valid, mq.size() != 0);
    check("m_evt_data", evt_data, exp_d);
`ifdef CORE_CTRL_OVF_CNT_EN
    check("m_ovf_cnt", ovf_cnt, m_cnt);
`endif
  end

  task automatic pulse(input logic h, input logic rdy, input logic clr,
                       output logic v2, output logic v3, output logic f3, output logic [3:0] ts3);
    hb = h;
    repeat (3) @(posedge clk);
    #1 phi = 1'b1;
    repeat (3) @(posedge clk);          // edges N, N+1, N+2
    #1 v2 = evt_valid;
    evt_ready = rdy;
    clr_ovf   = clr;
    @(posedge clk);                     // edge N+3
    #1 v3 = evt_valid;
    f3  = fb1;
    ts3 = evt_data[3:0];
    evt_ready = 1'b0;
    clr_ovf   = 1'b0;
    phi       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n, input int first_ts[8]);
    evt_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      check("drain_valid", evt_valid, 1'b1);
      check("drain_ts", evt_data[3:0], first_ts[i]);
      @(posedge clk);
      #1;
    end
    evt_ready = 1'b0;
    check("drain_empty", evt_valid, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic       v2, v3, f3;
    logic [3:0] ts3;
    int         cr[2], dr[2], lr[2];
    int         nc, nd, nl;
    logic       pc, pd, pl;
    int         exp_ts[8];

    rst = 1; en = 0; phi = 0; hb = 0; evt_ready = 0; clr_ovf = 0;
    cclk_half = 8'd3; lo_half = 8'd1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cclk", cclk, 0);
    check("rst_div2", div2, 0);
    check("rst_lo", lo, 0);
    check("rst_fb1", fb1, 0);
    check("rst_evt_valid", evt_valid, 0);
    check("rst_evt_data", evt_data, 0);
    check("rst_ovf", ovf, 0);
    rst = 0;
    @(posedge clk);
    #1 en = 1;

    // Clock generation: rising-edge positions counted from the first enabled edge.
    cr = '{0, 0}; dr = '{0, 0}; lr = '{0, 0};
    nc = 0; nd = 0; nl = 0; pc = 0; pd = 0; pl = 0;
    for (int k = 1; k <= 50; k++) begin
      @(posedge clk);
      #1;
      if (cclk && !pc && nc < 2) begin cr[nc] = k; nc++; end
      if (div2 && !pd && nd < 2) begin dr[nd] = k; nd++; end
      if (lo && !pl && nl < 2) begin lr[nl] = k; nl++; end
      pc = cclk; pd = div2; pl = lo;
    end
    check("cclk_first_rise", cr[0], 4);
    check("cclk_period", cr[1] - cr[0], 8);
    check("div2_first_rise", dr[0], 4);
    check("div2_period", dr[1] - dr[0], 16);
    check("lo_first_rise", lr[0], 12);
    check("lo_period", lr[1] - lr[0], 32);

    // Strobe response and timestamp progression.
    pulse(1, 0, 0, v2, v3, f3, ts3);
    check("strobe_valid_n2", v2, 0);
    check("strobe_valid_n3", v3, 1);
    check("strobe_fb1_n3", f3, 1);
    check("strobe_ts_n3", ts3, 0);
    pulse(0, 0, 0, v2, v3, f3, ts3);
    check("nodec_fb1", f3, 0);
    check("nodec_head_ts", ts3, 0);
    pulse(1, 0, 0, v2, v3, f3, ts3);
    exp_ts = '{0, 2, 0, 0, 0, 0, 0, 0};
    drain(2, exp_ts);

    // Overflow: nine events into eight entries (ts 3..11, ts 11 dropped).
    for (int i = 0; i < 9; i++) pulse(1, 0, 0, v2, v3, f3, ts3);
    check("ovf_set", ovf, 1);
    check("ovf_head_ts", evt_data[3:0], 3);
`ifdef CORE_CTRL_OVF_CNT_EN
    check("ovf_cnt_1", ovf_cnt, 1);
`endif
    pulse(1, 1, 0, v2, v3, f3, ts3);    // push+pop while full
    check("full_pushpop_head", evt_data[3:0], 4);
`ifdef CORE_CTRL_OVF_CNT_EN
    check("full_pushpop_cnt", ovf_cnt, 1);
`endif
    pulse(1, 0, 0, v2, v3, f3, ts3);    // plain drop
`ifdef CORE_CTRL_OVF_CNT_EN
    check("drop_cnt_2", ovf_cnt, 2);
`endif
    pulse(1, 0, 1, v2, v3, f3, ts3);    // drop coinciding with clr_ovf
    check("clr_drop_ovf", ovf, 1);
`ifdef CORE_CTRL_OVF_CNT_EN
    check("clr_drop_cnt", ovf_cnt, 1);
`endif
    clr_ovf = 1;
    @(posedge clk);
    #1 clr_ovf = 0;
    check("clr_ovf", ovf, 0);
`ifdef CORE_CTRL_OVF_CNT_EN
    check("clr_cnt", ovf_cnt, 0);
`endif
    exp_ts = '{4, 5, 6, 7, 8, 9, 10, 12};
    drain(8, exp_ts);

    // Timestamp wrap from a fresh reset: 16 non-firing strobes, then the 17th fires.
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < 16; i++) pulse(0, 0, 0, v2, v3, f3, ts3);
    pulse(1, 0, 0, v2, v3, f3, ts3);
    check("wrap_valid", v3, 1);
    check("wrap_ts", ts3, 0);

    // Reset mid-stream with three events queued and cclk high.
    pulse(1, 0, 0, v2, v3, f3, ts3);
    pulse(1, 0, 0, v2, v3, f3, ts3);
    for (int i = 0; i < 20 && !cclk; i++) begin
      @(posedge clk);
      #1;
    end
    check("pre_rst_cclk", cclk, 1);
    check("pre_rst_valid", evt_valid, 1);
    #1 rst = 1;
    #1;
    check("midrst_cclk", cclk, 0);
    check("midrst_div2", div2, 0);
    check("midrst_lo", lo, 0);
    check("midrst_fb1", fb1, 0);
    check("midrst_evt_valid", evt_valid, 0);
    check("midrst_evt_data", evt_data, 0);
    check("midrst_ovf", ovf, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    repeat (4) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
